imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles big-endian 32-bit words from a byte stream
// and writes them to consecutive word addresses, then releases the CPU.
module imem_loader #(
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int unsigned      LEN_W     = 7,
  localparam int unsigned      BYTE_W    = 8,
  localparam int unsigned      WORD_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_words,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_run
);

  localparam int unsigned MAX_WORDS = 64;
  localparam int unsigned PART_W    = WORD_W - BYTE_W;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [PART_W-1:0]   word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                we_q, ready_q, busy_q, done_q, run_q;
  logic                len_bad;

  assign len_bad = (len_words > LEN_W'(MAX_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (len_bad)                   state_d = S_IDLE;
          else if (len_words == '0)      state_d = S_DONE;
          else                           state_d = S_RECV;
        end
      end
      S_RECV:  if (byte_valid && (idx_q == 2'd3)) state_d = S_WRITE;
      S_WRITE: state_d = (cnt_q == LEN_W'(1)) ? S_DONE : S_RECV;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values; start is only honoured outside an active load.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            err_d  = 1'b0;
            cnt_d  = len_words;
            addr_d = BASE_ADDR;
            idx_d  = '0;
            word_d = '0;
          end
        end
      end
      S_RECV: begin
        if (byte_valid) begin
          word_d = {word_q[PART_W-BYTE_W-1:0], byte_in};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) wdata_d = {word_q, byte_in};
        end
      end
      S_WRITE: begin
        addr_d = addr_q + ADDR_W'(4);
        cnt_d  = cnt_q - LEN_W'(1);
        idx_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      we_q    <= (state_d == S_WRITE);
      ready_q <= (state_d == S_RECV);
      busy_q  <= (state_d == S_RECV) || (state_d == S_WRITE);
      done_q  <= (state_d == S_DONE);
      run_q   <= (state_d == S_DONE);
    end
  end

  assign byte_ready = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign cpu_run    = run_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes come from a byte list -> word/address model.
module tb_imem_loader;

  localparam logic [7:0] TB_BASE = 8'h00;

  logic        clk, rst_n, start, byte_valid;
  logic [6:0]  len_words;
  logic [7:0]  byte_in;
  logic        byte_ready, imem_we, busy, done, err, cpu_run;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(TB_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_words(len_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .cpu_run(cpu_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int feed_pos = 0;
  logic [7:0]  src_q[$];
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Every write strobe seen by the memory side.
  always @(negedge clk) if (imem_we === 1'b1) obs_q.push_back({imem_addr, imem_wdata});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: word w = bytes 4w..4w+3 big-endian, written at BASE + 4w (mod 256).
  task automatic build_exp(input int len);
    exp_q.delete();
    for (int w = 0; w < len; w++)
      exp_q.push_back({8'(int'(TB_BASE) + 4 * w), src_q[4*w], src_q[4*w+1], src_q[4*w+2], src_q[4*w+3]});
    feed_pos = 0;
    obs_q.delete();
  endtask

  task automatic prepare_random(input int len);
    src_q.delete();
    for (int i = 0; i < 4 * len; i++) src_q.push_back(8'($urandom));
    build_exp(len);
  endtask

  task automatic start_load(input int len);
    start = 1'b1;
    len_words = 7'(len);
    tick();
    start = 1'b0;
    len_words = 7'($urandom);
    start_cyc = cyc;
  endtask

  task automatic feed(input int n, input int max_gap, output bit to);
    int sent;
    int guard;
    int gap;
    sent = 0;
    to = 1'b0;
    while (sent < n && !to) begin
      gap = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
      byte_valid = 1'b0;
      byte_in = 8'($urandom);
      repeat (gap) tick();
      byte_in = src_q[feed_pos];
      byte_valid = 1'b1;
      guard = 0;
      while (byte_ready !== 1'b1 && guard < 50) begin
        tick();
        guard++;
      end
      if (byte_ready !== 1'b1) to = 1'b1;
      else begin
        tick();
        sent++;
        feed_pos++;
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit to);
    int guard;
    guard = 0;
    while (done !== 1'b1 && guard < 2000) begin
      tick();
      guard++;
    end
    to = (done !== 1'b1);
    cycles = cyc - start_cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; len_words = '0; byte_in = '0;
    repeat (3) tick();
    n_chk++;
    if ({byte_ready, imem_we, busy, done, err, cpu_run} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000000", {byte_ready, imem_we, busy, done, err, cpu_run});
    end
    n_chk++;
    if (imem_addr !== TB_BASE) begin
      n_fail++;
      $display("FAIL reset_addr: got %h expected %h", imem_addr, TB_BASE);
    end
    n_chk++;
    if (imem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_wdata: got %h expected 0", imem_wdata);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    bit to1, to2;
    int cycles;
    src_q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAC, 8'h02, 8'h00, 8'h08};
    build_exp(2);
    start_load(2);
    feed(8, 0, to1);
    wait_done(cycles, to2);
    n_chk++;
    if (to1 || to2 || cycles > 11) begin
      n_fail++;
      $display("FAIL directed_latency: got %0d cycles (timeout %0d) expected <= 11", cycles, to1 | to2);
    end
    n_chk++;
    if ({done, cpu_run, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL directed_status: got done/run/busy %b expected 110", {done, cpu_run, busy});
    end
    n_chk++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL directed_count: got %0d writes expected 2", obs_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL directed_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    obs_q.delete();
    start_load(0);
    tick();
    n_chk++;
    if ({done, cpu_run, busy, err} !== 4'b1100) begin
      n_fail++;
      $display("FAIL zero_len_status: got done/run/busy/err %b expected 1100", {done, cpu_run, busy, err});
    end
    repeat (3) tick();
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_len_writes: got %0d expected 0", obs_q.size());
    end
  endtask

  task automatic test_bad_len();
    bit leak;
    obs_q.delete();
    start_load(65);
    n_chk++;
    if ({err, done, cpu_run} !== 3'b100) begin
      n_fail++;
      $display("FAIL bad_len_65: got err/done/run %b expected 100", {err, done, cpu_run});
    end
    leak = 1'b0;
    byte_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      byte_in = 8'($urandom);
      if (byte_ready !== 1'b0 || busy !== 1'b0) leak = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    n_chk++;
    if (leak || obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL bad_len_quiet: got leak %0d writes %0d expected 0 0", leak, obs_q.size());
    end
    start_load(int'($urandom_range(127, 66)));
    n_chk++;
    if ({err, done, busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL bad_len_rand: got err/done/busy %b expected 100", {err, done, busy});
    end
    start_load(0);
    n_chk++;
    if ({err, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL bad_len_clear: got err/done %b expected 01", {err, done});
    end
  endtask

  task automatic test_random_loads();
    int len, gap, cycles;
    bit to1, to2;
    for (int it = 0; it < 6; it++) begin
      len = int'($urandom_range(12, 1));
      gap = (it % 2 == 1) ? 3 : 0;
      prepare_random(len);
      start_load(len);
      feed(4 * len, gap, to1);
      wait_done(cycles, to2);
      n_chk++;
      if (to1 || to2 || (gap == 0 && cycles > 5 * len)) begin
        n_fail++;
        $display("FAIL rand_timing%0d: got %0d cycles (timeout %0d) expected <= %0d", it, cycles, to1 | to2, 5 * len);
      end
      n_chk++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand_count%0d: got %0d expected %0d", it, obs_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          n_chk++;
          if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rand_write%0d_%0d: got %h expected %h", it, i, obs_q[i], exp_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_stall_start();
    int cycles;
    bit to;
    bit hold_bad;
    prepare_random(1);
    start_load(1);
    hold_bad = 1'b0;
    for (int b = 0; b < 4; b++) begin
      byte_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
        start = (b == 2 && g == 0);
        len_words = 7'd5;
        tick();
        start = 1'b0;
        if (busy !== 1'b1 || byte_ready !== 1'b1) hold_bad = 1'b1;
      end
      byte_in = src_q[b];
      byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    wait_done(cycles, to);
    n_chk++;
    if (hold_bad || to) begin
      n_fail++;
      $display("FAIL stall_hold: got hold_bad %0d timeout %0d expected 0 0", hold_bad, to);
    end
    n_chk++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL stall_count: got %0d expected 1", obs_q.size());
    end else begin
      n_chk++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL stall_write: got %h expected %h", obs_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_reset_midload();
    bit to, leak;
    prepare_random(3);
    start_load(3);
    feed(6, 0, to);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (to || {byte_ready, imem_we, busy, done, err, cpu_run} !== 6'b0 || imem_addr !== TB_BASE || imem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got flags %b addr %h wdata %h expected 000000 %h 0",
               {byte_ready, imem_we, busy, done, err, cpu_run}, imem_addr, imem_wdata, TB_BASE);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    leak = 1'b0;
    byte_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      byte_in = 8'($urandom);
      tick();
      if (byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) leak = 1'b1;
    end
    byte_valid = 1'b0;
    tick();
    n_chk++;
    if (leak) begin
      n_fail++;
      $display("FAIL midreset_resume: got activity after reset expected none");
    end
    n_chk++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d expected 1", obs_q.size());
    end else begin
      n_chk++;
      if (obs_q[0] !== exp_q[0]) begin
        n_fail++;
        $display("FAIL midreset_write: got %h expected %h", obs_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_restart();
    int cycles;
    bit to1, to2;
    start_load(0);
    tick();
    prepare_random(1);
    start_load(1);
    n_chk++;
    if ({cpu_run, done, busy} !== 3'b001) begin
      n_fail++;
      $display("FAIL restart_drop: got run/done/busy %b expected 001", {cpu_run, done, busy});
    end
    feed(4, 0, to1);
    wait_done(cycles, to2);
    n_chk++;
    if (to1 || to2 || {done, cpu_run} !== 2'b11) begin
      n_fail++;
      $display("FAIL restart_done: got done/run %b timeout %0d expected 11", {done, cpu_run}, to1 | to2);
    end
    n_chk++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      n_fail++;
      $display("FAIL restart_write: got %0d writes first %h expected 1 %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 40'h0, exp_q[0]);
    end
  endtask

  task automatic test_full_64();
    int cycles;
    bit to1, to2;
    logic [39:0] last;
    prepare_random(64);
    start_load(64);
    feed(256, 0, to1);
    wait_done(cycles, to2);
    n_chk++;
    if (to1 || to2 || cycles > 320) begin
      n_fail++;
      $display("FAIL full_timing: got %0d cycles (timeout %0d) expected <= 320", cycles, to1 | to2);
    end
    n_chk++;
    if (obs_q.size() != 64) begin
      n_fail++;
      $display("FAIL full_count: got %0d expected 64", obs_q.size());
    end else begin
      last = obs_q[63];
      n_chk++;
      if (last[39:32] !== 8'hFC) begin
        n_fail++;
        $display("FAIL full_last_addr: got %h expected fc", last[39:32]);
      end
      for (int i = 0; i < 64; i++) begin
        n_chk++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL full_write%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_len();
    test_bad_len();
    test_random_loads();
    test_stall_start();
    test_reset_midload();
    test_restart();
    test_full_64();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
